// File: rtl/pcpu_pkg.sv
// rtl/pcpu_pkg.sv - shared forwarding codes and widths for the PCPU hazard logic
package pcpu_pkg;

  localparam int AW_DEF = 5;

  localparam logic [2:0] FWD_RF  = 3'b000;
  localparam logic [2:0] FWD_EXE = 3'b001;
  localparam logic [2:0] FWD_MEM = 3'b010;
  localparam logic [2:0] FWD_LD  = 3'b011;
  localparam logic [2:0] FWD_MDU = 3'b100;

endpackage

// File: rtl/mdu_tracker.sv
// rtl/mdu_tracker.sv - tracks one in-flight multi-cycle MUL/DIV op and its destination
module mdu_tracker #(
  parameter int AW      = 5,
  parameter int MDU_LAT = 4
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          issue,
  input  logic [AW-1:0] issue_rn,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] rn
);

  logic [3:0] cnt;

  // A reload in the done cycle takes priority over the final decrement.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
      rn  <= '0;
    end else if (issue) begin
      cnt <= 4'(MDU_LAT);
      rn  <= issue_rn;
    end else if (cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign busy = (cnt != 4'd0);
  assign done = (cnt == 4'd1);

endmodule

// File: rtl/pipe_hazard_scoreboard.sv
// rtl/pipe_hazard_scoreboard.sv - ID-stage forwarding selects, stall generation and stall counter
module pipe_hazard_scoreboard
  import pcpu_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             id_valid,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [AW-1:0]    id_rs,
  input  logic [AW-1:0]    id_rt,
  input  logic             id_wreg,
  input  logic [AW-1:0]    id_wn,
  input  logic             id_mdu,
  input  logic             e_wreg,
  input  logic             e_m2reg,
  input  logic [AW-1:0]    e_rn,
  input  logic             m_wreg,
  input  logic             m_m2reg,
  input  logic [AW-1:0]    m_rn,
  input  logic             stall_clr,
  output logic             nostall,
  output logic [2:0]       fwda,
  output logic [2:0]       fwdb,
  output logic             mdu_issue,
  output logic             mdu_busy,
  output logic             mdu_done,
  output logic [AW-1:0]    mdu_rn,
  output logic [CNT_W-1:0] stall_cnt
);

  logic mdu_pend;
  logic stall_lu, stall_raw, stall_waw, stall_struct;

  mdu_tracker #(.AW(AW), .MDU_LAT(MDU_LAT)) u_mdu (
    .clock    (clock),
    .resetn   (resetn),
    .issue    (mdu_issue),
    .issue_rn (id_wn),
    .busy     (mdu_busy),
    .done     (mdu_done),
    .rn       (mdu_rn)
  );

  // MDU result wins: the WAW stall guarantees EXE/MEM writes to mdu_rn are older.
  function automatic logic [2:0] fwd_sel(input logic [AW-1:0] src);
    logic [2:0] sel;
    sel = FWD_RF;
    if (src != '0) begin
      if (mdu_done && mdu_rn == src)  sel = FWD_MDU;
      else if (e_wreg && e_rn == src) sel = e_m2reg ? FWD_RF : FWD_EXE;
      else if (m_wreg && m_rn == src) sel = m_m2reg ? FWD_LD : FWD_MEM;
    end
    return sel;
  endfunction

  always_comb begin
    fwda = fwd_sel(id_rs);
    fwdb = fwd_sel(id_rt);
  end

  assign mdu_pend = mdu_busy & ~mdu_done;

  always_comb begin
    stall_lu     = e_wreg & e_m2reg & (e_rn != '0) &
                   ((id_use_rs & (e_rn == id_rs)) | (id_use_rt & (e_rn == id_rt)));
    stall_raw    = mdu_pend & (mdu_rn != '0) &
                   ((id_use_rs & (mdu_rn == id_rs)) | (id_use_rt & (mdu_rn == id_rt)));
    stall_waw    = mdu_pend & id_wreg & (id_wn != '0) & (id_wn == mdu_rn);
    stall_struct = mdu_pend & id_mdu;
    nostall      = ~(id_valid & (stall_lu | stall_raw | stall_waw | stall_struct));
  end

  assign mdu_issue = id_valid & id_mdu & nostall;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stall_cnt <= '0;
    end else if (stall_clr) begin
      stall_cnt <= '0;
    end else if (id_valid && !nostall && stall_cnt != {CNT_W{1'b1}}) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// tb/tb_pipe_hazard_scoreboard.sv - vector table plus directed MDU/reset/counter sequences
module tb_pipe_hazard_scoreboard;

  logic       clock = 1'b0;
  logic       resetn;
  logic       id_valid, id_use_rs, id_use_rt, id_wreg, id_mdu;
  logic [4:0] id_rs, id_rt, id_wn;
  logic       e_wreg, e_m2reg, m_wreg, m_m2reg, stall_clr;
  logic [4:0] e_rn, m_rn;

  logic        nostall, mdu_issue, mdu_busy, mdu_done;
  logic [2:0]  fwda, fwdb;
  logic [4:0]  mdu_rn;
  logic [15:0] stall_cnt;

  logic        s_nostall, s_mdu_issue, s_mdu_busy, s_mdu_done;
  logic [2:0]  s_fwda, s_fwdb;
  logic [4:0]  s_mdu_rn;
  logic [3:0]  s_stall_cnt;

  int vec_n  = 0;
  int miss_n = 0;

  always #5 clock = ~clock;

  pipe_hazard_scoreboard #(.AW(5), .MDU_LAT(4), .CNT_W(16)) dut (
    .clock(clock), .resetn(resetn), .id_valid(id_valid), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .id_rs(id_rs), .id_rt(id_rt), .id_wreg(id_wreg), .id_wn(id_wn),
    .id_mdu(id_mdu), .e_wreg(e_wreg), .e_m2reg(e_m2reg), .e_rn(e_rn), .m_wreg(m_wreg),
    .m_m2reg(m_m2reg), .m_rn(m_rn), .stall_clr(stall_clr), .nostall(nostall), .fwda(fwda),
    .fwdb(fwdb), .mdu_issue(mdu_issue), .mdu_busy(mdu_busy), .mdu_done(mdu_done),
    .mdu_rn(mdu_rn), .stall_cnt(stall_cnt)
  );

  pipe_hazard_scoreboard #(.AW(5), .MDU_LAT(4), .CNT_W(4)) dut_sat (
    .clock(clock), .resetn(resetn), .id_valid(id_valid), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .id_rs(id_rs), .id_rt(id_rt), .id_wreg(id_wreg), .id_wn(id_wn),
    .id_mdu(id_mdu), .e_wreg(e_wreg), .e_m2reg(e_m2reg), .e_rn(e_rn), .m_wreg(m_wreg),
    .m_m2reg(m_m2reg), .m_rn(m_rn), .stall_clr(stall_clr), .nostall(s_nostall), .fwda(s_fwda),
    .fwdb(s_fwdb), .mdu_issue(s_mdu_issue), .mdu_busy(s_mdu_busy), .mdu_done(s_mdu_done),
    .mdu_rn(s_mdu_rn), .stall_cnt(s_stall_cnt)
  );

  typedef struct {
    logic       valid, use_rs, use_rt;
    logic [4:0] rs, rt;
    logic       ew, el;
    logic [4:0] ern;
    logic       mw, ml;
    logic [4:0] mrn;
    logic       x_nostall;
    logic [2:0] x_fwda, x_fwdb;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input int act, input int exp);
    vec_n++;
    if (act != exp) begin
      miss_n++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_use_rs = 0; id_use_rt = 0; id_rs = 0; id_rt = 0;
    id_wreg = 0; id_wn = 0; id_mdu = 0;
    e_wreg = 0; e_m2reg = 0; e_rn = 0; m_wreg = 0; m_m2reg = 0; m_rn = 0;
    stall_clr = 0;
  endtask

  task automatic id_instr(input logic mdu, input logic [4:0] wn, input logic ur,
                          input logic [4:0] rs, input logic ut, input logic [4:0] rt);
    id_valid = 1; id_mdu = mdu; id_wreg = 1; id_wn = wn;
    id_use_rs = ur; id_rs = rs; id_use_rt = ut; id_rt = rt;
  endtask

  initial begin
    //          v  urs urt rs  rt  ew el ern mw ml mrn  nostall fwda    fwdb
    vecs[0] = '{1, 1, 1, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 5'd0, 1, 3'b000, 3'b000};
    vecs[1] = '{1, 1, 1, 5'd5, 5'd1, 1, 1, 5'd5, 0, 0, 5'd0, 0, 3'b000, 3'b000};
    vecs[2] = '{1, 0, 1, 5'd5, 5'd1, 1, 1, 5'd5, 0, 0, 5'd0, 1, 3'b000, 3'b000};
    vecs[3] = '{1, 1, 0, 5'd3, 5'd0, 1, 0, 5'd3, 1, 1, 5'd3, 1, 3'b001, 3'b000};
    vecs[4] = '{1, 0, 1, 5'd9, 5'd3, 0, 0, 5'd0, 1, 1, 5'd3, 1, 3'b000, 3'b011};
    vecs[5] = '{1, 1, 1, 5'd2, 5'd2, 0, 0, 5'd0, 1, 0, 5'd2, 1, 3'b010, 3'b010};
    vecs[6] = '{1, 1, 1, 5'd0, 5'd0, 1, 0, 5'd0, 1, 1, 5'd0, 1, 3'b000, 3'b000};
    vecs[7] = '{0, 1, 1, 5'd5, 5'd5, 1, 1, 5'd5, 0, 0, 5'd0, 1, 3'b000, 3'b000};
    vecs[8] = '{1, 1, 0, 5'd4, 5'd7, 0, 0, 5'd4, 1, 0, 5'd4, 1, 3'b010, 3'b000};
    vecs[9] = '{1, 0, 1, 5'd1, 5'd6, 1, 1, 5'd6, 1, 0, 5'd1, 0, 3'b010, 3'b000};

    idle();
    resetn = 0;
    #2;
    chk("reset_busy", mdu_busy, 0);
    chk("reset_done", mdu_done, 0);
    chk("reset_cnt", stall_cnt, 0);
    chk("reset_nostall", nostall, 1);
    chk("reset_fwda", fwda, 0);
    step(); step();
    resetn = 1;
    step();

    for (int i = 0; i < 10; i++) begin
      idle();
      id_valid = vecs[i].valid; id_use_rs = vecs[i].use_rs; id_use_rt = vecs[i].use_rt;
      id_rs = vecs[i].rs; id_rt = vecs[i].rt;
      e_wreg = vecs[i].ew; e_m2reg = vecs[i].el; e_rn = vecs[i].ern;
      m_wreg = vecs[i].mw; m_m2reg = vecs[i].ml; m_rn = vecs[i].mrn;
      @(negedge clock);
      chk($sformatf("vec%0d_nostall", i), nostall, vecs[i].x_nostall);
      chk($sformatf("vec%0d_fwda", i), fwda, vecs[i].x_fwda);
      chk($sformatf("vec%0d_fwdb", i), fwdb, vecs[i].x_fwdb);
      step();
    end

    // lw r5 in EXE, add r6,r5,r1 in ID: one stall then load-data forward from MEM
    idle(); stall_clr = 1;
    step();
    idle();
    id_instr(0, 5'd6, 1, 5'd5, 1, 5'd1);
    e_wreg = 1; e_m2reg = 1; e_rn = 5'd5;
    @(negedge clock);
    chk("lu_nostall", nostall, 0);
    step();
    e_wreg = 0; e_m2reg = 0; e_rn = 0;
    m_wreg = 1; m_m2reg = 1; m_rn = 5'd5;
    @(negedge clock);
    chk("lu_fwda", fwda, 3'b011);
    chk("lu_nostall2", nostall, 1);
    chk("lu_cnt", stall_cnt, 1);
    step();

    // MUL r7 then add r8,r7,r0: three RAW stalls, then MDU forward in the done cycle
    idle();
    id_instr(1, 5'd7, 1, 5'd1, 1, 5'd2);
    @(negedge clock);
    chk("mul7_issue", mdu_issue, 1);
    step();
    idle();
    id_instr(0, 5'd8, 1, 5'd7, 1, 5'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk($sformatf("raw_stall%0d", i), nostall, 0);
      chk($sformatf("raw_done%0d", i), mdu_done, 0);
      step();
    end
    @(negedge clock);
    chk("raw_done", mdu_done, 1);
    chk("raw_fwda", fwda, 3'b100);
    chk("raw_nostall", nostall, 1);
    chk("raw_rn", mdu_rn, 7);
    step();
    idle();
    @(negedge clock);
    chk("mul7_idle", mdu_busy, 0);

    // MUL r4 busy: WAW on r4 stalls, r0 dest does not, mul r9 waits for done then issues
    step();
    id_instr(1, 5'd4, 0, 5'd0, 0, 5'd0);
    step();
    idle(); id_instr(0, 5'd4, 0, 5'd0, 0, 5'd0);
    @(negedge clock);
    chk("waw_stall", nostall, 0);
    step();
    idle(); id_instr(0, 5'd0, 0, 5'd0, 0, 5'd0);
    @(negedge clock);
    chk("waw_r0", nostall, 1);
    step();
    idle(); id_instr(1, 5'd9, 1, 5'd1, 0, 5'd0);
    @(negedge clock);
    chk("struct_stall", nostall, 0);
    chk("struct_noissue", mdu_issue, 0);
    step();
    @(negedge clock);
    chk("b2b_issue", mdu_issue, 1);
    chk("b2b_done", mdu_done, 1);
    step();
    idle();
    @(negedge clock);
    chk("b2b_rn", mdu_rn, 9);
    chk("b2b_busy", mdu_busy, 1);
    chk("b2b_done_drop", mdu_done, 0);

    // async reset while the r9 op is in flight
    step(); step();
    resetn = 0;
    #1;
    chk("arst_busy", mdu_busy, 0);
    chk("arst_rn", mdu_rn, 0);
    step();
    resetn = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk($sformatf("arst_nodone%0d", i), mdu_done, 0);
      step();
    end

    // MDU op with r0 destination occupies the unit but never hazards
    id_instr(1, 5'd0, 0, 5'd0, 0, 5'd0);
    step();
    idle(); id_instr(0, 5'd0, 1, 5'd0, 1, 5'd0);
    @(negedge clock);
    chk("r0_busy", mdu_busy, 1);
    chk("r0_nostall", nostall, 1);
    step(); step(); step();
    idle();
    step();

    // counter saturation (4-bit instance) and clear-beats-increment
    stall_clr = 1;
    step();
    stall_clr = 0;
    id_instr(0, 5'd6, 1, 5'd5, 0, 5'd0);
    e_wreg = 1; e_m2reg = 1; e_rn = 5'd5;
    repeat (20) step();
    @(negedge clock);
    chk("cnt_twenty", stall_cnt, 20);
    chk("cnt_sat", s_stall_cnt, 15);
    step();
    stall_clr = 1;
    step();
    @(negedge clock);
    chk("cnt_clr_wins", stall_cnt, 0);
    chk("cnt_clr_sat", s_stall_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
    $finish;
  end

endmodule
